// File: rtl/cardinal_ring_out_arb.sv
// cardinal_ring_out_arb
// Output-channel arbiter for one gold_ring router port. Up to NREQ requesters
// share one DW-bit ring link through two single-entry virtual-channel buffers.
// A free-running polarity bit p chooses which buffer may send (VC p) and which
// may accept (VC ~p), so a buffer is never read and written in the same cycle.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. Upstream, valid is req_si[k] and ready is
// req_ri[k]. Downstream, out_ro is the ready and out_so reports a completed
// send. req_ri is computed combinationally from req_si/req_di, so a requester
// must not make req_si depend on req_ri. A requester that is not granted keeps
// req_si and req_di stable until it is.

module cardinal_ring_out_arb #(
   parameter int DW   = 64,
   parameter int NREQ = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 polarity,
   input  logic [NREQ-1:0]      req_si,
   input  logic [NREQ*DW-1:0]   req_di,
   output logic [NREQ-1:0]      req_ri,
   output logic                 out_so,
   output logic [DW-1:0]        out_do,
   input  logic                 out_ro,
   output logic [1:0]           vc_full
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Registered state and next-state
   logic              pol_q, pol_d;
   logic [1:0]        full_q, full_d;
   logic [DW-1:0]     buf_q [2];
   logic [DW-1:0]     buf_d [2];
   logic [PW-1:0]     rr_q, rr_d;

   // Phase decode and arbitration results
   logic              send_vc;
   logic              acc_vc;
   logic              send;
   logic [NREQ-1:0]   eligible;
   logic [NREQ-1:0]   grant;
   logic              grant_any;
   logic [PW-1:0]     win_idx;
   logic [DW-1:0]     win_data;
   logic [PW:0]       scan_sum;
   logic [PW-1:0]     scan_idx;

   assign send_vc = pol_q;
   assign acc_vc  = ~pol_q;

   // Send side: a full send-VC goes out whenever downstream is ready
   always_comb begin
      send   = full_q[send_vc] & out_ro;
      out_so = send;
      out_do = full_q[send_vc] ? buf_q[send_vc] : '0;
   end

   // A requester is eligible only if its packet's VC bit matches the accept VC
   always_comb begin
      eligible = '0;
      for (int k = 0; k < NREQ; k++) begin
         eligible[k] = req_si[k] & (req_di[k*DW] == acc_vc);
      end
   end

   // Round-robin scan starting at rr_q; grants are suppressed in reset or when the accept VC is occupied
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      win_idx   = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      if (reset && !full_q[acc_vc]) begin
         for (int i = 0; i < NREQ; i++) begin
            scan_sum = {1'b0, rr_q} + (PW+1)'(i);
            if (scan_sum >= (PW+1)'(NREQ)) begin
               scan_sum = scan_sum - (PW+1)'(NREQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (!grant_any && eligible[scan_idx]) begin
               grant_any       = 1'b1;
               win_idx         = scan_idx;
               grant[scan_idx] = 1'b1;
            end
         end
      end
   end

   // One-hot AND-OR mux of the winning requester's packet
   always_comb begin
      win_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         win_data = win_data | ({DW{grant[k]}} & req_di[k*DW +: DW]);
      end
   end

   // Next-state: send empties VC p, accept fills VC ~p; the two never touch the same buffer
   always_comb begin
      pol_d  = ~pol_q;
      full_d = full_q;
      buf_d  = buf_q;
      rr_d   = rr_q;
      if (send) begin
         full_d[send_vc] = 1'b0;
      end
      if (grant_any) begin
         full_d[acc_vc] = 1'b1;
         buf_d[acc_vc]  = win_data;
         rr_d           = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
      end
   end

   // State registers; reset discards any buffered packets
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pol_q    <= 1'b0;
         full_q   <= 2'b00;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         rr_q     <= '0;
      end else begin
         pol_q    <= pol_d;
         full_q   <= full_d;
         buf_q[0] <= buf_d[0];
         buf_q[1] <= buf_d[1];
         rr_q     <= rr_d;
      end
   end

   assign req_ri   = grant;
   assign vc_full  = full_q;
   assign polarity = pol_q;

endmodule

// File: tb/tb_cardinal_ring_out_arb.sv
// Testbench for cardinal_ring_out_arb: directed phase checks followed by a
// randomized run, all compared against a behavioural model of the scheduler.

module tb_cardinal_ring_out_arb;

   localparam int DW   = 64;
   localparam int NREQ = 3;

   // Clock / reset and DUT signals
   logic                clk = 1'b0;
   logic                reset;
   logic                polarity;
   logic [NREQ-1:0]     req_si;
   logic [NREQ*DW-1:0]  req_di;
   logic [NREQ-1:0]     req_ri;
   logic                out_so;
   logic [DW-1:0]       out_do;
   logic                out_ro;
   logic [1:0]          vc_full;

   always #5 clk = ~clk;

   cardinal_ring_out_arb #(.DW(DW), .NREQ(NREQ)) dut (
      .clk      (clk),
      .reset    (reset),
      .polarity (polarity),
      .req_si   (req_si),
      .req_di   (req_di),
      .req_ri   (req_ri),
      .out_so   (out_so),
      .out_do   (out_do),
      .out_ro   (out_ro),
      .vc_full  (vc_full)
   );

   // Counters
   int n_vec = 0;
   int n_err = 0;

   // Reference model state: polarity, per-VC occupancy/data, round-robin start
   bit              m_pol;
   bit [1:0]        m_full;
   logic [DW-1:0]   m_buf [2];
   int              m_rr;

   // Values observed by the last run_cycle call
   logic [NREQ-1:0] last_ri;
   logic            last_so;
   logic [DW-1:0]   last_do;

   // Random-phase requester state
   bit              pend [NREQ];
   logic [DW-1:0]   pkt  [NREQ];
   logic [DW-1:0]   fill_data [2];

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pol    = 1'b0;
      m_full   = 2'b00;
      m_buf[0] = '0;
      m_buf[1] = '0;
      m_rr     = 0;
   endtask

   // Winner = eligible requester closest to m_rr going upward mod NREQ
   function automatic int pick_winner();
      int t;
      int best;
      int bestd;
      int d;
      t     = m_pol ? 0 : 1;
      best  = -1;
      bestd = NREQ;
      if (m_full[t]) return -1;
      for (int k = 0; k < NREQ; k++) begin
         if (req_si[k] && (int'(req_di[k*DW]) == t)) begin
            d = (k - m_rr + NREQ) % NREQ;
            if (d < bestd) begin
               bestd = d;
               best  = k;
            end
         end
      end
      return best;
   endfunction

   // Called at a falling edge with inputs already driven; checks, then advances one clock
   task automatic run_cycle(output int win);
      logic [NREQ-1:0] exp_ri;
      bit              sv;
      bit              exp_so;
      logic [DW-1:0]   exp_do;
      #1;
      win    = pick_winner();
      exp_ri = (win >= 0) ? (NREQ'(1) << win) : '0;
      sv     = m_pol;
      exp_so = m_full[sv] && out_ro;
      exp_do = m_full[sv] ? m_buf[sv] : '0;
      last_ri = req_ri;
      last_so = out_so;
      last_do = out_do;
      check_eq("polarity", polarity, m_pol);
      check_eq("vc_full", vc_full, m_full);
      check_eq("req_ri", req_ri, exp_ri);
      check_eq("out_so", out_so, exp_so);
      check_eq("out_do", out_do, exp_do);
      @(posedge clk);
      if (exp_so) m_full[sv] = 1'b0;
      if (win >= 0) begin
         m_full[!sv] = 1'b1;
         m_buf[!sv]  = req_di[win*DW +: DW];
         m_rr        = (win + 1) % NREQ;
      end
      m_pol = !m_pol;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ri"}, req_ri, '0);
      check_eq({tag, "_so"}, out_so, '0);
      check_eq({tag, "_do"}, out_do, '0);
      check_eq({tag, "_full"}, vc_full, '0);
      check_eq({tag, "_pol"}, polarity, '0);
   endtask

   // Reset held low n cycles with requests pending; released on a falling edge
   task automatic do_reset(input int n);
      reset  = 1'b0;
      req_si = '1;
      out_ro = 1'b1;
      for (int k = 0; k < NREQ; k++) req_di[k*DW +: DW] = {$urandom, $urandom};
      model_reset();
      for (int i = 0; i < n; i++) begin
         #1 check_reset_outputs("rst");
         @(negedge clk);
      end
      req_si = '0;
      reset  = 1'b1;
   endtask

   function automatic logic [DW-1:0] rand_pkt(input bit vc);
      logic [DW-1:0] p;
      p    = {$urandom, $urandom};
      p[0] = vc;
      return p;
   endfunction

   initial begin
      int w;
      bit pb;
      reset  = 1'b0;
      req_si = '0;
      req_di = '0;
      out_ro = 1'b0;
      model_reset();
      @(negedge clk);

      // Reset for 3 cycles, then polarity runs 0,1,0,1
      do_reset(3);
      for (int i = 0; i < 4; i++) begin
         check_eq("pol_seq", polarity, (i % 2));
         run_cycle(w);
      end

      // Single VC1 packet at p=0 is granted, then sent one cycle later
      req_si = 3'b001;
      req_di[0 +: DW] = 64'h8000_0000_0000_00AB;
      run_cycle(w);
      check_eq("t2_grant", last_ri, 3'b001);
      req_si = '0;
      run_cycle(w);
      check_eq("t2_so", last_so, 1'b1);
      check_eq("t2_do", last_do, 64'h8000_0000_0000_00AB);
      check_eq("t2_empty", vc_full, 2'b00);

      // All requesters eligible every cycle: strict rotation from req0
      do_reset(2);
      for (int i = 0; i < 6; i++) begin
         req_si = '1;
         for (int k = 0; k < NREQ; k++) req_di[k*DW +: DW] = rand_pkt(!m_pol);
         run_cycle(w);
         check_eq("t3_order", last_ri, NREQ'(1) << (i % 3));
      end
      req_si = '0;
      run_cycle(w);
      run_cycle(w);

      // Downstream stalled: both VCs fill, grants stop, data held, then drain
      out_ro = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_si = 3'b001;
         req_di[0 +: DW] = rand_pkt(!m_pol);
         fill_data[!m_pol] = req_di[0 +: DW];
         run_cycle(w);
      end
      check_eq("t4_full", vc_full, 2'b11);
      req_si = 3'b100;
      req_di[2*DW +: DW] = rand_pkt(!m_pol);
      pb = m_pol;
      run_cycle(w);
      check_eq("t4_noack", last_ri, '0);
      check_eq("t4_hold", last_do, fill_data[pb]);
      check_eq("t4_stall", last_so, 1'b0);
      req_si = '0;
      out_ro = 1'b1;
      run_cycle(w);
      check_eq("t4_drain0", last_so, 1'b1);
      run_cycle(w);
      check_eq("t4_drain1", last_so, 1'b1);
      check_eq("t4_empty", vc_full, 2'b00);

      // VC mismatch at p=0 waits one cycle, then wins after the flip
      if (m_pol) run_cycle(w);
      req_si = 3'b010;
      req_di[DW +: DW] = rand_pkt(1'b0);
      run_cycle(w);
      check_eq("t5_wait", last_ri, 3'b000);
      run_cycle(w);
      check_eq("t5_grant", last_ri, 3'b010);
      req_si = '0;
      run_cycle(w);
      run_cycle(w);

      // Both VCs full with rr at 2, then asynchronous reset mid-cycle
      out_ro = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_si = 3'b010;
         req_di[DW +: DW] = rand_pkt(!m_pol);
         run_cycle(w);
      end
      check_eq("t6_full", vc_full, 2'b11);
      req_si = '0;
      out_ro = 1'b1;
      #2 reset = 1'b0;
      #1;
      check_eq("t6_full_rst", vc_full, 2'b00);
      check_eq("t6_so_rst", out_so, 1'b0);
      check_eq("t6_ri_rst", req_ri, '0);
      model_reset();
      @(negedge clk);
      do_reset(1);
      req_si = '1;
      for (int k = 0; k < NREQ; k++) req_di[k*DW +: DW] = rand_pkt(1'b1);
      run_cycle(w);
      check_eq("t6_first", last_ri, 3'b001);
      req_si = '0;
      run_cycle(w);
      run_cycle(w);

      // Randomized traffic with requesters holding packets until granted
      for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
               pend[k] = 1'b1;
               pkt[k]  = {$urandom, $urandom};
            end
            req_si[k] = pend[k];
            req_di[k*DW +: DW] = pkt[k];
         end
         out_ro = ($urandom_range(0, 3) != 0);
         run_cycle(w);
         if (w >= 0) pend[w] = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
